// File: rtl/iotdf_pkg.sv
// rtl/iotdf_pkg.sv - shared widths, serializer states and helpers for the IoT result drain
package iotdf_pkg;

    localparam int REC_W     = 128;
    localparam int BYTE_W    = 8;
    localparam int REC_BYTES = 16;
    localparam int DROP_W    = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/iot_out_drain_if.sv
// rtl/iot_out_drain_if.sv - result strobe input and byte stream output of the drain stage
interface iot_out_drain_if;
    import iotdf_pkg::*;

    logic              in_valid;
    logic [REC_W-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [BYTE_W-1:0] out_data;
    logic              out_last;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_last
    );

endinterface

// File: rtl/iot_rec_fifo.sv
// rtl/iot_rec_fifo.sv - DEPTH x W register FIFO with count/full/empty, head visible combinationally
module iot_rec_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign pop_data = mem[rd_ptr];
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);

    // storage is not reset; only pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst) !(pop && empty));
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop));

endmodule

// File: rtl/iot_out_drain.sv
// rtl/iot_out_drain.sv - buffers 128-bit filter results and serializes them MSB byte first
module iot_out_drain
    import iotdf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    iot_out_drain_if.slave         bus,
    input  logic                   clr_ovf,
    output logic [$clog2(DEPTH):0] fifo_cnt,
    output logic                   ovf,
    output logic [DROP_W-1:0]      drop_cnt
);

    localparam int               IDX_W    = $clog2(REC_BYTES);
    localparam logic [0:0]       ST_IDLE  = IDLE;
    localparam logic [0:0]       ST_SEND  = SEND;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_BYTES - 1);

    logic [0:0]       state;
    logic [REC_W-1:0] shift;
    logic [IDX_W-1:0] idx;

    logic             xfer;
    logic             last_xfer;
    logic             pop;
    logic             push;
    logic             drop;
    logic [REC_W-1:0] head;
    logic             full;
    logic             empty;

    assign xfer      = (state == ST_SEND) && bus.out_ready;
    assign last_xfer = xfer && (idx == LAST_IDX);
    // reloading on the final byte keeps back-to-back records gap free
    assign pop       = !empty && ((state == ST_IDLE) || last_xfer);
    assign push      = bus.in_valid && (!full || pop);
    assign drop      = bus.in_valid && !push;

    iot_rec_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.in_data),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_cnt),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            shift <= '0;
            idx   <= '0;
        end else if (pop) begin
            state <= ST_SEND;
            shift <= head;
            idx   <= '0;
        end else if (xfer) begin
            shift <= shift << BYTE_W;
            idx   <= idx + 1'b1;
            if (last_xfer) begin
                state <= ST_IDLE;
            end
        end
    end

    assign bus.out_valid = (state == ST_SEND);
    assign bus.out_data  = shift[REC_W-1 -: BYTE_W];
    assign bus.out_last  = (state == ST_SEND) && (idx == LAST_IDX);

    // a drop in the same cycle as a clear restarts the count at one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf      <= 1'b1;
            drop_cnt <= clr_ovf ? DROP_W'(1) : sat_inc(drop_cnt);
        end else if (clr_ovf) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_iot_out_drain.sv
// tb/tb_iot_out_drain.sv - randomized self-checking bench for iot_out_drain against a queue model
module tb_iot_out_drain;
    import iotdf_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [127:0] REC = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr_ovf;
    logic [CW-1:0] fifo_cnt;
    logic ovf;
    logic [7:0] drop_cnt;

    always #5 clk = ~clk;

    iot_out_drain_if bus();

    iot_out_drain #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .clr_ovf  (clr_ovf),
        .fifo_cnt (fifo_cnt),
        .ovf      (ovf),
        .drop_cnt (drop_cnt)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]   m_ser[$];
    logic [127:0] m_fifo[$];
    logic         m_ovf = 1'b0;
    int           m_drop = 0;

    function automatic logic [127:0] rnd_rec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_ser.delete();
        m_fifo.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    task automatic model_edge(input logic iv, input logic [127:0] d, input logic ordy, input logic clr);
        bit sending, xfer, finishing, pop, acc;
        logic [127:0] r;
        sending   = m_ser.size() > 0;
        xfer      = sending && ordy;
        finishing = xfer && (m_ser.size() == 1);
        pop       = (m_fifo.size() > 0) && (!sending || finishing);
        acc       = iv && ((m_fifo.size() < DEPTH) || pop);
        if (xfer) void'(m_ser.pop_front());
        if (pop) begin
            r = m_fifo.pop_front();
            for (int k = 0; k < 16; k++) m_ser.push_back(r[127-8*k -: 8]);
        end
        if (acc) m_fifo.push_back(d);
        if (iv && !acc) begin
            m_ovf  = 1'b1;
            m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
        end else if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
    endtask

    task automatic drive(input logic iv, input logic [127:0] d, input logic ordy, input logic clr);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        clr_ovf       = clr;
        model_edge(iv, d, ordy, clr);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        clr_ovf      = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_last} !== 10'h0) begin
            errors++;
            $display("FAIL reset_out: got v=%b d=%h l=%b expected all 0", bus.out_valid, bus.out_data, bus.out_last);
        end
        checks++;
        if ({fifo_cnt, ovf, drop_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_status: got cnt=%0d ovf=%b drop=%0d expected 0", fifo_cnt, ovf, drop_cnt);
        end
    endtask

    task automatic test_single();
        drive(1'b1, REC, 1'b1, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_t1_valid: got %b expected 0", bus.out_valid);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({bus.out_valid, bus.out_data, bus.out_last} !== {1'b1, 8'(i * 17), (i == 15)}) begin
                errors++;
                $display("FAIL single_byte%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                         i, bus.out_valid, bus.out_data, bus.out_last, 8'(i * 17), (i == 15));
            end
            drive(1'b0, '0, 1'b1, 1'b0);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_stall();
        int nb, cyc;
        logic ordy, prev_stall;
        logic [7:0] prev_data;
        nb = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
        drive(1'b1, REC, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int n = 0; n < 100 && nb < 16; n++) begin
            ordy = n[0];
            if (bus.out_valid) cyc++;
            if (prev_stall) begin
                checks++;
                if (bus.out_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: got %h expected %h", bus.out_data, prev_data);
                end
            end
            if (bus.out_valid && ordy) begin
                checks++;
                if ({bus.out_data, bus.out_last} !== {8'(nb * 17), (nb == 15)}) begin
                    errors++;
                    $display("FAIL stall_byte%0d: got d=%h l=%b expected d=%h l=%b",
                             nb, bus.out_data, bus.out_last, 8'(nb * 17), (nb == 15));
                end
                nb++;
            end
            prev_stall = bus.out_valid && !ordy;
            prev_data  = bus.out_data;
            drive(1'b0, '0, ordy, 1'b0);
        end
        checks++;
        if (cyc != 32 || nb != 16) begin
            errors++;
            $display("FAIL stall_cycles: got cycles=%0d bytes=%0d expected 32 and 16", cyc, nb);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] a, b;
        logic [7:0] exp[32];
        a = rnd_rec();
        b = rnd_rec();
        for (int k = 0; k < 16; k++) begin
            exp[k]      = a[127-8*k -: 8];
            exp[k + 16] = b[127-8*k -: 8];
        end
        drive(1'b1, a, 1'b1, 1'b0);
        drive(1'b1, b, 1'b1, 1'b0);
        for (int j = 0; j < 32; j++) begin
            checks++;
            if ({bus.out_valid, bus.out_data, bus.out_last} !== {1'b1, exp[j], (j == 15 || j == 31)}) begin
                errors++;
                $display("FAIL b2b_byte%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                         j, bus.out_valid, bus.out_data, bus.out_last, exp[j], (j == 15 || j == 31));
            end
            drive(1'b0, '0, 1'b1, 1'b0);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_overflow();
        int guard;
        for (int s = 0; s < 6; s++) drive(1'b1, rnd_rec(), 1'b0, 1'b0);
        checks++;
        if ({fifo_cnt, ovf, drop_cnt} !== {CW'(4), 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL ovf_first: got cnt=%0d ovf=%b drop=%0d expected 4 1 1", fifo_cnt, ovf, drop_cnt);
        end
        drive(1'b1, rnd_rec(), 1'b0, 1'b0);
        checks++;
        if ({ovf, drop_cnt} !== {1'b1, 8'd2}) begin
            errors++;
            $display("FAIL ovf_second: got ovf=%b drop=%0d expected 1 2", ovf, drop_cnt);
        end
        drive(1'b1, rnd_rec(), 1'b0, 1'b1);
        checks++;
        if ({ovf, drop_cnt} !== {1'b1, 8'd1}) begin
            errors++;
            $display("FAIL ovf_clr_vs_drop: got ovf=%b drop=%0d expected 1 1", ovf, drop_cnt);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if ({ovf, drop_cnt} !== {1'b0, 8'd0}) begin
            errors++;
            $display("FAIL ovf_clear: got ovf=%b drop=%0d expected 0 0", ovf, drop_cnt);
        end
        guard = 0;
        while (m_ser.size() != 1 && guard < 40) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            guard++;
        end
        checks++;
        if (guard >= 40 || bus.out_last !== 1'b1 || fifo_cnt !== CW'(4)) begin
            errors++;
            $display("FAIL full_pop_setup: got last=%b cnt=%0d guard=%0d expected last=1 cnt=4", bus.out_last, fifo_cnt, guard);
        end
        drive(1'b1, rnd_rec(), 1'b1, 1'b0);
        checks++;
        if ({fifo_cnt, ovf, drop_cnt} !== {CW'(4), 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL full_pop_write: got cnt=%0d ovf=%b drop=%0d expected 4 0 0", fifo_cnt, ovf, drop_cnt);
        end
        guard = 0;
        while ((m_ser.size() > 0 || m_fifo.size() > 0) && guard < 200) begin
            checks++;
            if (bus.out_valid !== 1'b1 || {bus.out_data, bus.out_last} !== {m_ser[0], m_ser.size() == 1}) begin
                errors++;
                $display("FAIL full_drain: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                         bus.out_valid, bus.out_data, bus.out_last, m_ser[0], m_ser.size() == 1);
            end
            drive(1'b0, '0, 1'b1, 1'b0);
            guard++;
        end
        checks++;
        if (guard >= 200 || bus.out_valid !== 1'b0 || fifo_cnt !== '0) begin
            errors++;
            $display("FAIL full_drain_end: got v=%b cnt=%0d guard=%0d expected 0 0", bus.out_valid, fifo_cnt, guard);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        logic [127:0] d;
        drive(1'b1, rnd_rec(), 1'b1, 1'b0);
        drive(1'b1, rnd_rec(), 1'b1, 1'b0);
        drive(1'b1, rnd_rec(), 1'b1, 1'b0);
        guard = 0;
        while (m_ser.size() != 9 && guard < 40) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            guard++;
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_last, fifo_cnt, ovf, drop_cnt} !== '0 || guard >= 40) begin
            errors++;
            $display("FAIL reset_mid: got v=%b d=%h l=%b cnt=%0d ovf=%b drop=%0d expected all 0",
                     bus.out_valid, bus.out_data, bus.out_last, fifo_cnt, ovf, drop_cnt);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        d = rnd_rec();
        drive(1'b1, d, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_last} !== {1'b1, d[127:120], 1'b0}) begin
            errors++;
            $display("FAIL reset_restart: got v=%b d=%h l=%b expected v=1 d=%h l=0",
                     bus.out_valid, bus.out_data, bus.out_last, d[127:120]);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({bus.out_valid, bus.out_data, bus.out_last} !== {1'b1, d[127-8*i -: 8], (i == 15)}) begin
                errors++;
                $display("FAIL reset_drain%0d: got v=%b d=%h l=%b expected d=%h", i,
                         bus.out_valid, bus.out_data, bus.out_last, d[127-8*i -: 8]);
            end
            drive(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_random();
        logic iv, ordy, clr;
        for (int c = 0; c < 800; c++) begin
            checks++;
            if (bus.out_valid !== (m_ser.size() > 0)) begin
                errors++;
                $display("FAIL rnd_valid@%0d: got %b expected %b", c, bus.out_valid, (m_ser.size() > 0));
            end
            if (m_ser.size() > 0) begin
                checks++;
                if ({bus.out_data, bus.out_last} !== {m_ser[0], m_ser.size() == 1}) begin
                    errors++;
                    $display("FAIL rnd_data@%0d: got d=%h l=%b expected d=%h l=%b",
                             c, bus.out_data, bus.out_last, m_ser[0], m_ser.size() == 1);
                end
            end
            checks++;
            if ({fifo_cnt, ovf, drop_cnt} !== {CW'(m_fifo.size()), m_ovf, 8'(m_drop)}) begin
                errors++;
                $display("FAIL rnd_status@%0d: got cnt=%0d ovf=%b drop=%0d expected %0d %b %0d",
                         c, fifo_cnt, ovf, drop_cnt, m_fifo.size(), m_ovf, m_drop);
            end
            if (c < 400) begin
                iv   = ($urandom_range(0, 7) == 0);
                ordy = ($urandom_range(0, 3) != 0);
            end else begin
                iv   = ($urandom_range(0, 2) == 0);
                ordy = ($urandom_range(0, 1) == 0);
            end
            clr = ($urandom_range(0, 39) == 0);
            drive(iv, rnd_rec(), ordy, clr);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        clr_ovf       = 1'b0;
        rst           = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_single();
        test_stall();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iot_out_drain.md
# iot_out_drain

Result-drain stage directly downstream of the IoT data-filtering core. Captures each 128-bit result word presented with a one-cycle `valid` pulse into a small FIFO. Serializes the stored records MSB-byte-first onto an 8-bit ready/valid stream toward the host interface. The filter core never back-pressures (`busy` is tied low), so drops under overflow are counted and flagged instead of stalled.

## Interface
- `DEPTH`, 4: record FIFO depth, power of two, ≥2.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  one-cycle result strobe (filter `valid`).
- `in_data`  in  128  result word (filter `iot_out`), sampled only when `in_valid`=1.
- `out_valid`  out  1  byte available on `out_data`.
- `out_ready`  in  1  sink accepts byte; a transfer occurs when `out_valid`&&`out_ready`.
- `out_data`  out  8  current byte; byte 0 = `in_data[127:120]`, byte 15 = `in_data[7:0]`.
- `out_last`  out  1  high with byte 15 of a record.
- `fifo_cnt`  out  $clog2(DEPTH)+1  records held in the FIFO, excluding the one being serialized.
- `ovf`  out  1  sticky overflow flag.
- `clr_ovf`  in  1  clears `ovf` and `drop_cnt`.
- `drop_cnt`  out  8  dropped records, saturates at 255.

## Operation
- Reset (`rst`=0, asynchronous) clears all outputs to 0, FIFO pointers, serializer state (IDLE), byte index and shift register.
- FIFO write accepted iff `in_valid` && (`fifo_cnt`<DEPTH || a pop occurs the same cycle). Otherwise the record is dropped: `ovf`<=1 and `drop_cnt`<=min(`drop_cnt`+1,255).
- `clr_ovf` and a drop in the same cycle: the drop wins. `ovf`=1 and `drop_cnt`=1.
- Serializer FSM:
  - IDLE: `out_valid`=0. If FIFO not empty, pop head into 128-bit shift register, byte index<=0, go to SEND.
  - SEND: `out_valid`=1, `out_data`=shift[127:120], `out_last`=(index==15). On transfer, shift left 8 and index+1.
  - On transfer of byte 15: if FIFO not empty, pop next record and stay in SEND (no bubble). Otherwise go to IDLE.
- `out_data`/`out_last` must stay stable while `out_valid`=1 and `out_ready`=0.
- Pointers wrap modulo DEPTH. `fifo_cnt` updates on write/pop; a simultaneous write and pop leaves it unchanged.

## Timing
- Write at edge t (`in_valid` high in cycle t). If IDLE, the record is popped at edge t+1 and `out_valid` rises in cycle t+2. Minimum input-to-first-byte latency is 2 cycles.
- With `out_ready` held at 1, a record drains in 16 consecutive cycles. Back-to-back records have no gap.
- Sustained throughput is 1 record/16 cycles. The filter's peak rate (1 record/16 input cycles in extract modes) is therefore matched, and DEPTH absorbs bursts.
- `ovf`/`drop_cnt` update one edge after the dropped strobe.
- Reset mid-record discards the partial record and all FIFO contents. `out_valid` falls asynchronously with `rst`.

## Structure
- Shared package `iotdf_pkg`: `REC_W`=128, `BYTE_W`=8, `REC_BYTES`=16, `DROP_W`=8, and the FSM state enum {IDLE, SEND}.
- Sub-module `iot_rec_fifo`: a synchronous DEPTH×128 register FIFO with push/pop/count/full/empty. It uses the same `clk`/`rst`.
- Top level holds the serializer FSM, shift register, byte index and overflow logic.

## Test plan
- Single record `in_data`=128'h00112233_44556677_8899AABB_CCDDEEFF, `out_ready`=1 → `out_valid` from cycle t+2. Bytes 00,11,…,FF over 16 cycles, `out_last` only on FF, then IDLE.
- Same record with `out_ready` toggling 1/0 each cycle → 32 cycles to drain. Byte order is unchanged, and `out_data` is held stable during stalls.
- Two strobes 1 cycle apart, `out_ready`=1 → 32 contiguous bytes with no `out_valid` gap. `out_last` is high at bytes 16 and 32.
- `out_ready`=0 and DEPTH+2=6 strobes → FIFO fills to 4 (1 record in shift register plus 4 stored). The 6th strobe is dropped: `ovf`=1, `drop_cnt`=1. Then pulse `clr_ovf` → both return to 0.
- Full FIFO with a pop (final byte transfer) in the same cycle as `in_valid` → write accepted, no drop, `fifo_cnt` unchanged.
- Assert `rst`=0 during byte 7 of a record, then release → all outputs 0 and `fifo_cnt`=0. The next strobe drains cleanly from byte 0.
